// File: rtl/add16_seq.sv
// Sequencer for the shared 16-bit adder: runs ADD HL,rr / ADD SP,e8 / LD HL,SP+e8 / INC-DEC rr
// through their internal M-cycles and issues one write-back and flag-update pulse per instruction.
module add16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_tick,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        dec,
  input  logic [1:0]  rr_sel,
  input  logic [15:0] rr_val,
  input  logic [15:0] hl_val,
  input  logic [15:0] sp_val,
  input  logic [7:0]  e8,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_control,
  input  logic [15:0] add_y,
  input  logic [3:0]  add_f,
  output logic        busy,
  output logic        done,
  output logic        wb_en,
  output logic [1:0]  wb_dst,
  output logic [15:0] wb_data,
  output logic [3:0]  flags_we,
  output logic [3:0]  flags
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned FLAG_W = 4;

  localparam logic [1:0] OP_ADD_HL_RR  = 2'b00;
  localparam logic [1:0] OP_ADD_SP_E8  = 2'b01;
  localparam logic [1:0] OP_LD_HL_SPE8 = 2'b10;
  localparam logic [1:0] OP_INCDEC     = 2'b11;

  localparam logic [SEL_W-1:0] SEL_HL = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_SP = SEL_W'(3);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_capture;
  logic [FLAG_W-1:0]    w_flags_we_nxt;

  logic [1:0]           r_op;
  logic [DATA_W-1:0]    r_a;
  logic [DATA_W-1:0]    r_b;
  logic [SEL_W-1:0]     r_dst;
  logic                 r_add_control;
  logic [DATA_W-1:0]    r_wb_data;
  logic [SEL_W-1:0]     r_wb_dst;
  logic [FLAG_W-1:0]    r_flags;
  logic [FLAG_W-1:0]    r_flags_we;
  logic                 r_busy;
  logic                 r_done;

  logic [DATA_W-1:0]    w_sext_e8;
  logic [DATA_W-1:0]    w_a_nxt;
  logic [DATA_W-1:0]    w_b_nxt;
  logic [SEL_W-1:0]     w_dst_nxt;
  logic                 w_ctl_nxt;
  logic                 w_unused_f;

  // Adder only reports H and C; the upper flag bits are don't-care.
  assign w_unused_f = ^add_f[FLAG_W-1:2];

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state, accept/capture strobes and the flag write mask for the DONE cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    w_flags_we_nxt = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (m_tick) begin
          w_capture   = 1'b1;
          w_state_nxt = (r_op == OP_ADD_SP_E8) ? ST_HOLD : ST_DONE;
        end
      end
      ST_HOLD: begin
        if (m_tick) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_state_nxt == ST_DONE) begin
      unique case (r_op)
        OP_ADD_HL_RR:  w_flags_we_nxt = 4'b0111;
        OP_ADD_SP_E8:  w_flags_we_nxt = 4'b1111;
        OP_LD_HL_SPE8: w_flags_we_nxt = 4'b1111;
        default:       w_flags_we_nxt = 4'b0000;
      endcase
    end
  end

  // Operand selection for the instruction being accepted
  always_comb begin
    w_sext_e8 = {{(DATA_W-IMM_W){e8[IMM_W-1]}}, e8};
    w_a_nxt   = hl_val;
    w_b_nxt   = rr_val;
    w_dst_nxt = SEL_HL;
    w_ctl_nxt = 1'b1;
    unique case (op)
      OP_ADD_HL_RR: begin
        w_a_nxt   = hl_val;
        w_b_nxt   = rr_val;
        w_dst_nxt = SEL_HL;
        w_ctl_nxt = 1'b1;
      end
      OP_ADD_SP_E8: begin
        w_a_nxt   = sp_val;
        w_b_nxt   = w_sext_e8;
        w_dst_nxt = SEL_SP;
        w_ctl_nxt = 1'b0;
      end
      OP_LD_HL_SPE8: begin
        w_a_nxt   = sp_val;
        w_b_nxt   = w_sext_e8;
        w_dst_nxt = SEL_HL;
        w_ctl_nxt = 1'b0;
      end
      default: begin
        w_a_nxt   = rr_val;
        w_b_nxt   = dec ? {DATA_W{1'b1}} : DATA_W'(1);
        w_dst_nxt = rr_sel;
        w_ctl_nxt = 1'b1;
      end
    endcase
  end

  // Operand latch, result capture and registered status/pulse outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op          <= OP_ADD_HL_RR;
      r_a           <= '0;
      r_b           <= '0;
      r_dst         <= '0;
      r_add_control <= 1'b1;
      r_wb_data     <= '0;
      r_wb_dst      <= '0;
      r_flags       <= '0;
      r_flags_we    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
      r_flags_we <= w_flags_we_nxt;
      if (w_accept) begin
        r_op          <= op;
        r_a           <= w_a_nxt;
        r_b           <= w_b_nxt;
        r_dst         <= w_dst_nxt;
        r_add_control <= w_ctl_nxt;
      end
      if (w_capture) begin
        r_wb_data <= add_y;
        r_wb_dst  <= r_dst;
        r_flags   <= {2'b00, add_f[1:0]};
      end
    end
  end

  assign add_a       = r_a;
  assign add_b       = r_b;
  assign add_control = r_add_control;
  assign busy        = r_busy;
  assign done        = r_done;
  assign wb_en       = r_done;
  assign wb_dst      = r_wb_dst;
  assign wb_data     = r_wb_data;
  assign flags_we    = r_flags_we;
  assign flags       = r_flags;

endmodule

// File: tb/tb_add16_seq.sv
// Randomized self-checking bench for add16_seq with a behavioural adder and instruction-level model.
module tb_add16_seq;

  logic        clk;
  logic        reset;
  logic        m_tick;
  logic        start;
  logic [1:0]  op;
  logic        dec;
  logic [1:0]  rr_sel;
  logic [15:0] rr_val;
  logic [15:0] hl_val;
  logic [15:0] sp_val;
  logic [7:0]  e8;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_control;
  logic [15:0] add_y;
  logic [3:0]  add_f;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [1:0]  wb_dst;
  logic [15:0] wb_data;
  logic [3:0]  flags_we;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  add16_seq dut (
    .clk(clk), .reset(reset), .m_tick(m_tick), .start(start), .op(op), .dec(dec),
    .rr_sel(rr_sel), .rr_val(rr_val), .hl_val(hl_val), .sp_val(sp_val), .e8(e8),
    .add_a(add_a), .add_b(add_b), .add_control(add_control), .add_y(add_y), .add_f(add_f),
    .busy(busy), .done(done), .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
    .flags_we(flags_we), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared adder: carry-into-bit vector gives half/full carries at 8- or 16-bit width
  logic [16:0] sum17;
  logic [16:0] cin;
  always_comb begin
    sum17 = {1'b0, add_a} + {1'b0, add_b};
    cin   = sum17 ^ {1'b0, add_a ^ add_b};
    add_y = sum17[15:0];
    if (add_control) add_f = {2'b00, cin[12], cin[16]};
    else             add_f = {2'b00, cin[4],  cin[8]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One instruction: reference result computed from the instruction semantics
  task automatic run_txn(input logic [1:0] t_op, input logic t_dec, input logic [1:0] t_sel,
                         input logic [15:0] t_rr, input logic [15:0] t_hl, input logic [15:0] t_sp,
                         input logic [7:0] t_e8, input bit t_tick_on_start, input bit t_noise);
    int unsigned a, b, y, imm;
    int          e;
    logic [15:0] ea, eb, ey;
    logic [1:0]  edst;
    logic        ectl, eh, ec;
    logic [3:0]  efwe, eflags;
    int          need, ticks;
    bit          got_done;

    e = (t_e8 >= 8'd128) ? int'(t_e8) - 256 : int'(t_e8);
    case (t_op)
      2'd0:    begin a = t_hl; b = t_rr;        edst = 2'd2;  ectl = 1'b1; need = 1; efwe = 4'b0111; end
      2'd1:    begin a = t_sp; b = 16'(e);      edst = 2'd3;  ectl = 1'b0; need = 2; efwe = 4'b1111; end
      2'd2:    begin a = t_sp; b = 16'(e);      edst = 2'd2;  ectl = 1'b0; need = 1; efwe = 4'b1111; end
      default: begin a = t_rr; b = t_dec ? 32'hFFFF : 32'd1; edst = t_sel; ectl = 1'b1; need = 1; efwe = 4'b0000; end
    endcase
    y = (a + b) % 65536;
    if (ectl) begin
      eh = ((a % 4096) + (b % 4096)) >= 4096;
      ec = (a + b) >= 65536;
    end else begin
      eh = ((a % 16) + (b % 16)) >= 16;
      ec = ((a % 256) + (b % 256)) >= 256;
    end
    imm    = 0;
    ea     = 16'(a);
    eb     = 16'(b);
    ey     = 16'(y + imm);
    eflags = {2'b00, eh, ec};

    op = t_op; dec = t_dec; rr_sel = t_sel; rr_val = t_rr; hl_val = t_hl; sp_val = t_sp; e8 = t_e8;
    start = 1'b1; m_tick = t_tick_on_start;
    @(posedge clk); #1;
    start = 1'b0; m_tick = 1'b0;
    check("busy_exec", busy, 1);
    check("done_early", done, 0);
    check("add_a", add_a, ea);
    check("add_b", add_b, eb);
    check("add_control", add_control, ectl);

    ticks = 0;
    got_done = 0;
    for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
      if (t_noise) begin
        start = 1'($urandom); op = 2'($urandom); dec = 1'($urandom); rr_sel = 2'($urandom);
        rr_val = 16'($urandom); hl_val = 16'($urandom); sp_val = 16'($urandom); e8 = 8'($urandom);
      end
      m_tick = (ticks < need) && ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      if (m_tick) ticks++;
      if (ticks == need) begin
        got_done = 1;
        check("done", done, 1);
        check("wb_en", wb_en, 1);
        check("wb_dst", wb_dst, edst);
        check("wb_data", wb_data, ey);
        check("flags_we", flags_we, efwe);
        check("flags", flags & efwe, eflags & efwe);
      end else begin
        check("no_done", done, 0);
        check("busy_wait", busy, 1);
        check("operand_hold", {add_a, add_b}, {ea, eb});
        if (ticks > 0) check("data_hold", wb_data, ey);
      end
    end
    if (!got_done) check("timeout", 0, 1);

    start = 1'b0; m_tick = 1'($urandom);
    @(posedge clk); #1;
    m_tick = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", {done, wb_en}, 0);
    check("idle_flags_we", flags_we, 0);
    check("idle_wb", {wb_dst, wb_data}, {edst, ey});
    check("idle_flags", flags & efwe, eflags & efwe);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pulse"}, {done, wb_en, flags_we}, 0);
    check({tag, "_wb"}, {wb_dst, wb_data, flags}, 0);
    check({tag, "_ops"}, {add_a, add_b, add_control}, 33'h1);
  endtask

  // Reset while in HOLD (after_ticks=1, ADD SP) or in DONE (ADD HL)
  task automatic reset_mid(input logic [1:0] t_op, input string tag);
    op = t_op; hl_val = 16'h1234; sp_val = 16'h1234; rr_val = 16'h4321; e8 = 8'h80;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; m_tick = 1'b1;
    @(posedge clk); #1;
    m_tick = 1'b0;
    check({tag, "_busy_pre"}, busy, 1);
    check({tag, "_done_pre"}, done, (t_op == 2'd0) ? 1 : 0);
    reset = 1'b1; m_tick = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs(tag);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check({tag, "_quiet"}, {busy, done, wb_en}, 0);
    end
    m_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; m_tick = 1'b0; start = 1'b0; op = 2'd0; dec = 1'b0; rr_sel = 2'd0;
    rr_val = '0; hl_val = '0; sp_val = '0; e8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    run_txn(2'd0, 1'b0, 2'd1, 16'h0001, 16'h0FFF, 16'h0000, 8'h00, 1'b0, 1'b0);
    run_txn(2'd1, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'hFFF8, 8'h08, 1'b0, 1'b0);
    run_txn(2'd2, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h0005, 8'hFE, 1'b0, 1'b0);
    run_txn(2'd3, 1'b1, 2'd1, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);
    run_txn(2'd3, 1'b0, 2'd1, 16'hFFFF, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);
    run_txn(2'd0, 1'b0, 2'd3, 16'h8000, 16'h8000, 16'h0000, 8'h00, 1'b1, 1'b1);
    run_txn(2'd1, 1'b0, 2'd0, 16'h0000, 16'h0000, 16'h00FF, 8'h81, 1'b1, 1'b1);

    reset_mid(2'd1, "rst_hold");
    reset_mid(2'd0, "rst_done");

    for (int n = 0; n < 150; n++) begin
      run_txn(2'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
